// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Purpose:
//   Bundles the control and address signals exchanged between the fetch unit
//   and its surroundings (decode / branch resolution / instruction memory).
//
// Parameters:
//   PC_W   width of program counter / instruction-memory address
//   CNT_W  width of the performance counters
//
// Signals:
//   start          one-cycle pulse, begin fetching from the start address
//   stall          decode not ready, re-present the current instruction
//   halt           decode saw a halt instruction (qualified by inst_valid)
//   br_taken       taken branch/jump resolved this cycle
//   br_target      absolute redirect target
//   pc             address presented to instruction memory
//   inst_pc        PC of the instruction currently on the memory output
//   inst_valid     memory output is a real, non-squashed instruction
//   done           high while the fetch unit is halted
//   fetch_count    instructions accepted by decode
//   redirect_count taken redirects
//
// Modports:
//   master  the side issuing control (decode / branch unit)
//   slave   the fetch unit itself
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stall;
    logic             halt;
    logic             br_taken;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  inst_pc;
    logic             inst_valid;
    logic             done;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output start, stall, halt, br_taken, br_target,
        input  pc, inst_pc, inst_valid, done, fetch_count, redirect_count
    );

    modport slave (
        input  start, stall, halt, br_taken, br_target,
        output pc, inst_pc, inst_valid, done, fetch_count, redirect_count
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Program-counter and fetch sequencer in front of a synchronous-read
//   instruction memory (one-cycle read latency). It drives the memory address,
//   tracks which PC the memory output belongs to, and marks that output valid
//   or squashed. Handles start/halt, decode stalls and taken-branch redirects.
//
// Parameters:
//   PC_W        width of program counter / instruction-memory address
//   START_ADDR  PC loaded on reset and on every start
//   CNT_W       width of the performance counters
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    fetch_unit_if.slave (start, stall, halt, br_taken, br_target in;
//          pc, inst_pc, inst_valid, done, fetch_count, redirect_count out)
//
// Configuration:
//   FETCH_PERF_CNT_EN  when defined, fetch_count / redirect_count are
//                      saturating counters cleared only by reset; otherwise
//                      both outputs are tied to zero and no counters exist.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inst_pc_q;
    logic [PC_W-1:0] pc_out;
    logic            inst_valid_q, inst_valid_d;
    logic            done_q, done_d;
    logic            halt_ok;
    logic            start_ok;

    // A halt is only meaningful when it belongs to a real instruction.
    assign halt_ok  = bus.halt && inst_valid_q;
    // start is ignored while running.
    assign start_ok = bus.start && (state_q != S_RUN);

    // -------------------------------------------------------------------------
    // Address mux. While stalling, the memory re-reads the address of the
    // instruction on its output so the output stays put. On a start from
    // HALTED, pc_q still holds the frozen halt address, so the start address
    // is presented directly (in IDLE pc_q already equals it).
    // -------------------------------------------------------------------------
    always_comb begin
        pc_out = pc_q;
        if (start_ok) begin
            pc_out = START_PC;
        end else if ((state_q == S_RUN) && bus.stall && !bus.br_taken && !bus.halt) begin
            pc_out = inst_pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. In RUN the priority is halt > branch > stall > step.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        done_d       = done_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                inst_valid_d = 1'b0;
                if (bus.start) begin
                    // Start address is read this cycle, so the next fetch
                    // address is one past it and the output is valid next.
                    state_d      = S_RUN;
                    pc_d         = START_PC + PC_ONE;
                    inst_valid_d = 1'b1;
                    done_d       = 1'b0;
                end
            end

            S_RUN: begin
                if (halt_ok) begin
                    state_d      = S_HALTED;
                    inst_valid_d = 1'b0;
                    done_d       = 1'b1;
                end else if (bus.br_taken) begin
                    // The address read this cycle is on the wrong path, so
                    // its memory output is squashed for one cycle.
                    pc_d         = bus.br_target;
                    inst_valid_d = 1'b0;
                end else if (bus.stall) begin
                    pc_d         = pc_q;
                end else begin
                    pc_d         = pc_q + PC_ONE;
                    inst_valid_d = 1'b1;
                end
            end

            default: begin
                state_d      = S_IDLE;
                pc_d         = START_PC;
                inst_valid_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. inst_pc always records the address actually presented,
    // which is what the memory output corresponds to one cycle later.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= START_PC;
            inst_pc_q    <= START_PC;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_pc_q    <= pc_out;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.pc         = pc_out;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.done       = done_q;

    // -------------------------------------------------------------------------
    // Optional performance counters.
    // -------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_q;
    logic             fetch_inc;
    logic             redirect_inc;

    // An instruction is accepted when it is valid and decode neither stalls
    // nor halts on it.
    assign fetch_inc    = (state_q == S_RUN) && inst_valid_q && !bus.stall && !bus.halt;
    assign redirect_inc = (state_q == S_RUN) && bus.br_taken && !bus.halt;

    // Cleared by reset only; a new start keeps accumulating.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (fetch_inc && (fetch_cnt_q != CNT_MAX)) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
            end
            if (redirect_inc && (redirect_cnt_q != CNT_MAX)) begin
                redirect_cnt_q <= redirect_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.fetch_count    = fetch_cnt_q;
    assign bus.redirect_count = redirect_cnt_q;
`else
    assign bus.fetch_count    = '0;
    assign bus.redirect_count = '0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch sequencer that drives the address input of the synchronous-read instruction memory (8-bit address, 9-bit instruction, one-cycle read latency). Tracks which PC the memory output currently corresponds to and flags it valid or squashed. Handles start/halt, stalls from decode, and taken-branch redirects. Sits directly upstream of instruction memory; its inst_pc/inst_valid travel alongside the memory output into decode.

Parameters:
PC_W, 8, width of program counter / instruction-memory address
START_ADDR, 0, PC loaded on reset and on every start
CNT_W, 16, width of performance counters (used only with FETCH_PERF_CNT_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins fetching from START_ADDR (honoured in IDLE and HALTED)
stall  input  1  decode not ready; current instruction must be re-presented
halt  input  1  decode saw halt instruction (qualified by inst_valid)
br_taken  input  1  taken branch/jump resolved this cycle
br_target  input  PC_W  absolute redirect target
pc  output  PC_W  address to instruction memory (combinational mux, see Behaviour)
inst_pc  output  PC_W  PC of the instruction currently on the memory output
inst_valid  output  1  memory output is a real, non-squashed instruction
done  output  1  high while in HALTED
fetch_count  output  CNT_W  instructions accepted by decode
redirect_count  output  CNT_W  taken redirects

Behaviour:
- States: IDLE, RUN, HALTED. Reset -> IDLE; pc_q=START_ADDR, inst_pc=START_ADDR, inst_valid=0, done=0, counters=0.
- pc output = inst_pc when (state==RUN && stall && !br_taken && !halt), else pc_q. Memory read latency 1: memory output at cycle t+1 = mem[pc at edge t]. Every edge: inst_pc <= pc (the address actually presented).
- IDLE: inst_valid=0, pc_q holds START_ADDR. start -> RUN, pc_q<=START_ADDR+1, inst_valid<=1 (so inst[START_ADDR] valid the following cycle).
- RUN, priority halt > br_taken > stall > increment:
  - halt && inst_valid: -> HALTED, inst_valid<=0, done<=1, pc_q holds. Same-cycle br_taken/stall ignored.
  - br_taken: pc_q<=br_target, inst_valid<=0 (wrong-path fetch squashed for exactly one cycle); next edge pc_q<=br_target+1, inst_valid<=1, inst_pc==br_target. Overrides stall.
  - stall: pc_q holds, memory re-reads inst_pc, inst_valid unchanged; output instruction identical for all stall cycles.
  - otherwise pc_q<=pc_q+1, inst_valid<=1.
  - halt with inst_valid=0 ignored.
- PC arithmetic modulo 2^PC_W: 255+1 -> 0, no flag; br_target+1 wraps likewise.
- HALTED: done=1, inst_valid=0, pc_q frozen. start -> identical to IDLE start path, done<=0. start in RUN ignored.
- reset in any state/cycle wins over all inputs; returns to IDLE next edge with reset values.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, fetch_count increments each RUN cycle with inst_valid && !stall && !halt; redirect_count increments each RUN cycle with br_taken && !halt. Both saturate at 2^CNT_W-1, clear on reset only (not on start). When undefined, both outputs are tied to 0 and no counter registers exist.

Test Plan:
- Reset then start at cycle 0 -> cycle 1: inst_pc=0, inst_valid=1; cycles 2,3: inst_pc=1,2; pc leads inst_pc by 1.
- Stall for 3 cycles while inst_pc=5 -> pc=5, inst_pc=5, inst_valid=1 for all 3 cycles; after release inst_pc=6 next cycle.
- br_taken with br_target=0x40 while inst_pc=10 -> next cycle inst_valid=0; following cycle inst_pc=0x40, inst_valid=1; br_taken+stall same cycle behaves identically.
- Free run from START_ADDR=0xFE -> inst_pc sequence FE, FF, 00, 01, no stop.
- halt at inst_pc=7 with br_taken also high -> done=1, inst_valid=0 next cycle, pc frozen; start -> inst_pc=START_ADDR valid one cycle later, done=0.
- With FETCH_PERF_CNT_EN: 10 valid fetches, 2 stall cycles, 1 redirect -> fetch_count=10, redirect_count=1; reset mid-RUN -> IDLE, counters 0, inst_valid=0.
